// File: rtl/cu_pkg.sv
// Shared types and encodings for the accumulator CPU control unit.
// State enum, opcodes, bus encodings and the control word struct.
package cu_pkg;

  typedef enum logic [3:0] {
    RST, F1, F2, DEC,
    A1, A2, A3, L4, L5,
    S4, J3, SKIP, EX, HALT
  } state_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDAC = 8'h01;
  localparam logic [7:0] OP_STAC = 8'h02;
  localparam logic [7:0] OP_MVAC = 8'h03;
  localparam logic [7:0] OP_MOVR = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;
  localparam logic [7:0] OP_INAC = 8'h07;
  localparam logic [7:0] OP_CLAC = 8'h08;
  localparam logic [7:0] OP_JUMP = 8'h09;
  localparam logic [7:0] OP_JMPZ = 8'h0A;
  localparam logic [7:0] OP_JPNZ = 8'h0B;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic [2:0] RD_AC  = 3'd0;
  localparam logic [2:0] RD_AR  = 3'd1;
  localparam logic [2:0] RD_PC  = 3'd2;
  localparam logic [2:0] RD_DR  = 3'd3;
  localparam logic [2:0] RD_TR  = 3'd4;
  localparam logic [2:0] RD_RAM = 3'd5;
  localparam logic [2:0] RD_R   = 3'd6;
  localparam logic [2:0] RD_IR  = 3'd7;

  localparam logic [2:0] WR_NONE = 3'd0;
  localparam logic [2:0] WR_AC   = 3'd1;
  localparam logic [2:0] WR_AR   = 3'd2;
  localparam logic [2:0] WR_DR   = 3'd3;
  localparam logic [2:0] WR_IR   = 3'd4;
  localparam logic [2:0] WR_PC   = 3'd5;
  localparam logic [2:0] WR_R    = 3'd6;
  localparam logic [2:0] WR_RAM  = 3'd7;

  localparam logic [2:0] INC_NONE = 3'd0;
  localparam logic [2:0] INC_AC   = 3'd1;
  localparam logic [2:0] INC_AR   = 3'd2;
  localparam logic [2:0] INC_DR   = 3'd3;
  localparam logic [2:0] INC_IR   = 3'd4;
  localparam logic [2:0] INC_PC   = 3'd5;
  localparam logic [2:0] INC_R    = 3'd6;
  localparam logic [2:0] INC_TR   = 3'd7;

  localparam logic [3:0] ALU_HOLD = 4'd0;
  localparam logic [3:0] ALU_PASS = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_INC  = 4'd4;
  localparam logic [3:0] ALU_CLR  = 4'd5;

  typedef struct packed {
    logic [3:0] alu_con;
    logic [2:0] read_en;
    logic [2:0] inc_en;
    logic [2:0] write_en;
  } ctrl_word_t;

  function automatic ctrl_word_t cw(
    input logic [3:0] alu,
    input logic [2:0] rd,
    input logic [2:0] inc,
    input logic [2:0] wr
  );
    ctrl_word_t w;
    w.alu_con  = alu;
    w.read_en  = rd;
    w.inc_en   = inc;
    w.write_en = wr;
    return w;
  endfunction

endpackage

// File: rtl/cu_if.sv
// Control unit <-> datapath bundle.
// master: sequencer side, slave: datapath side.
interface cu_if
  import cu_pkg::*;
#(
  parameter int OPW   = 8,
  parameter int CNT_W = 16
);
  logic [OPW-1:0]   ir_opcode;
  logic             z;
  logic [3:0]       alu_con;
  logic [2:0]       read_en;
  logic [2:0]       inc_en;
  logic [2:0]       write_en;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  ir_opcode, z,
    output alu_con, read_en, inc_en,
    output write_en, halted, instr_count
  );

  modport slave (
    output ir_opcode, z,
    input  alu_con, read_en, inc_en,
    input  write_en, halted, instr_count
  );
endinterface

// File: rtl/cu_word_rom.sv
// Control word lookup: state plus latched opcode -> ctrl_word_t.
// Purely combinational so it can be swept in isolation.
module cu_word_rom
  import cu_pkg::*;
#(
  parameter int OPW = 8
) (
  input  state_t         state,
  input  logic [OPW-1:0] op,
  output ctrl_word_t     word
);

  always_comb begin
    word = '0;
    unique case (state)
      F1:   word = cw(ALU_HOLD, RD_PC,  INC_NONE, WR_AR);
      F2:   word = cw(ALU_HOLD, RD_RAM, INC_PC,   WR_IR);
      A1:   word = cw(ALU_HOLD, RD_PC,  INC_NONE, WR_AR);
      A2:   word = cw(ALU_HOLD, RD_RAM, INC_PC,   WR_DR);
      A3:   word = cw(ALU_HOLD, RD_DR,  INC_NONE, WR_AR);
      L4:   word = cw(ALU_HOLD, RD_RAM, INC_NONE, WR_DR);
      L5:   word = cw(ALU_PASS, RD_DR,  INC_NONE, WR_AC);
      S4:   word = cw(ALU_HOLD, RD_AC,  INC_NONE, WR_RAM);
      J3:   word = cw(ALU_HOLD, RD_DR,  INC_NONE, WR_PC);
      SKIP: word = cw(ALU_HOLD, RD_AC,  INC_PC,   WR_NONE);
      EX: begin
        case (op)
          OP_MVAC: word = cw(ALU_HOLD, RD_AC, INC_NONE, WR_R);
          OP_MOVR: word = cw(ALU_PASS, RD_R,  INC_NONE, WR_AC);
          OP_ADD:  word = cw(ALU_ADD,  RD_R,  INC_NONE, WR_AC);
          OP_SUB:  word = cw(ALU_SUB,  RD_R,  INC_NONE, WR_AC);
          OP_INAC: word = cw(ALU_INC,  RD_AC, INC_NONE, WR_AC);
          OP_CLAC: word = cw(ALU_CLR,  RD_AC, INC_NONE, WR_AC);
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Define CU_INSTR_COUNT_EN to enable the retired-instruction counter.
module control_unit
  import cu_pkg::*;
#(
  parameter int             OPW     = 8,
  parameter int             CNT_W   = 16,
  parameter logic [OPW-1:0] HALT_OP = 8'hFF
) (
  input  logic clk,
  input  logic rst_n,
  cu_if.master bus
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  ctrl_word_t     word;
  logic           is_mem, is_alu;
  logic           is_jz, is_jnz, is_jmp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    is_mem = (bus.ir_opcode == OP_LDAC)
          || (bus.ir_opcode == OP_STAC)
          || (bus.ir_opcode == OP_JUMP);
    is_alu = (bus.ir_opcode >= OP_MVAC)
          && (bus.ir_opcode <= OP_CLAC);
    is_jz  = (bus.ir_opcode == OP_JMPZ);
    is_jnz = (bus.ir_opcode == OP_JPNZ);
    is_jmp = (op_q == OP_JUMP)
          || (op_q == OP_JMPZ)
          || (op_q == OP_JPNZ);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      RST: state_d = F1;
      F1:  state_d = F2;
      F2:  state_d = DEC;
      DEC: begin
        // z is only looked at here; the opcode is held for later states
        op_d = bus.ir_opcode;
        unique case (1'b1)
          bus.ir_opcode == HALT_OP: state_d = HALT;
          is_mem:  state_d = A1;
          is_jz:   state_d = bus.z ? A1 : SKIP;
          is_jnz:  state_d = bus.z ? SKIP : A1;
          is_alu:  state_d = EX;
          default: state_d = F1;
        endcase
      end
      A1: state_d = A2;
      A2: state_d = is_jmp ? J3 : A3;
      A3: state_d = (op_q == OP_LDAC) ? L4 : S4;
      L4: state_d = L5;
      L5, S4, J3, SKIP, EX: state_d = F1;
      HALT: state_d = HALT;
      default: state_d = RST;
    endcase
  end

  cu_word_rom #(.OPW(OPW)) u_rom (
    .state (state_q),
    .op    (op_q),
    .word  (word)
  );

  assign bus.alu_con  = word.alu_con;
  assign bus.read_en  = word.read_en;
  assign bus.inc_en   = word.inc_en;
  assign bus.write_en = word.write_en;
  assign bus.halted   = (state_q == HALT);

`ifdef CU_INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (state_q == DEC
             && bus.ir_opcode != HALT_OP)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.instr_count = cnt_q;
`else
  assign bus.instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Microprogrammed-style hardwired sequencer for the 16-bit accumulator CPU.
- Sits directly upstream of the Processor datapath and drives its ALUCon, ReadEN, Inc and WriteEN inputs.
- Consumes IROUT (opcode) and z from the datapath.
- Runs a fetch/decode/execute FSM: exactly one bus transfer per clock.

Parameters:
- OPW, 8, opcode width (matches IROUT).
- CNT_W, 16, width of instr_count.
- HALT_OP, 8'hFF, opcode that enters HALT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ir_opcode  in  8  IR[7:0] from datapath (IROUT).
- z  in  1  ALU zero flag from datapath.
- alu_con  out  4  to ALUCon.
- read_en  out  3  bus source select, to ReadEN.
- inc_en  out  3  increment select, to Inc.
- write_en  out  3  destination select, to WriteEN.
- halted  out  1  high while in HALT.
- instr_count  out  CNT_W  retired-instruction count (see Optional Feature).

Behaviour:
- Reset: one clock, synchronous, active-low; rst_n sampled low at clk edge -> state RST. Reset mid-instruction aborts it.
- Outputs are a Moore decode of the state register.
- In RST all outputs are 0: alu_con=0, read_en=0, inc_en=0, write_en=0 (no write, no RAM write), halted=0, instr_count=0.
- RST -> F1 on the first edge with rst_n high.
- Encodings (package constants):
  - read_en: 0 AC, 1 AR, 2 PC, 3 DR, 4 TR, 5 RAM, 6 R, 7 IR.
  - write_en: 0 none, 1 AC, 2 AR, 3 DR, 4 IR, 5 PC, 6 R, 7 RAM.
  - inc_en: 0 none, 1 AC, 2 AR, 3 DR, 4 IR, 5 PC, 6 R, 7 TR.
  - alu_con: 0 HOLD, 1 PASS(bus), 2 ADD(AC+bus), 3 SUB(AC-bus), 4 INC, 5 CLR.
  - When write_en!=AC, alu_con=HOLD.
- Fetch:
  - F1: read PC, write AR.
  - F2: read RAM, write IR, inc PC.
  - DEC: all-zero word; branch on ir_opcode.
- Opcodes and execute states (all return to F1):
  - 00 NOP: none.
  - 01 LDAC: A1, A2, A3, L4, L5.
  - 02 STAC: A1, A2, A3, S4.
  - 03 MVAC: read AC, write R.
  - 04 MOVR: read R, PASS, write AC.
  - 05 ADD: read R, ADD, write AC.
  - 06 SUB: read R, SUB, write AC.
  - 07 INAC: INC, write AC.
  - 08 CLAC: CLR, write AC.
  - 09 JUMP: A1, A2, J3.
  - 0A JMPZ: JUMP path if z=1, else SKIP.
  - 0B JPNZ: JUMP path if z=0, else SKIP.
  - FF HALT.
  - Any other opcode: NOP.
- Execute-state control words:
  - A1: read PC, write AR.
  - A2: read RAM, write DR, inc PC.
  - A3: read DR, write AR.
  - L4: read RAM, write DR.
  - L5: read DR, PASS, write AC.
  - S4: read AC, write RAM.
  - J3: read DR, write PC.
  - SKIP: inc PC (steps over the operand word).
- z is sampled only in DEC.
- Latency (cycles, F1 through last execute state):
  - NOP: 3. Register/ALU ops: 4. JUMP: 6. JMPZ/JPNZ taken: 6, not taken: 4. STAC: 7. LDAC: 8.
- HALT: absorbing; all-zero word, halted=1 until reset.
- Never more than one write_en and one inc_en asserted per cycle (guaranteed by encoding).
- Outputs change only on clk edges; no combinational path from ir_opcode or z to outputs.

Optional Feature:
- Macro: CU_INSTR_COUNT_EN.
- Defined:
  - instr_count increments by 1 on each DEC cycle whose opcode is not HALT_OP.
  - Wraps at 2^CNT_W-1 -> 0.
  - Cleared by reset.
- Undefined: instr_count tied to 0; no counter flops.

Decomposition:
- Package cu_pkg holds:
  - state enum (RST, F1, F2, DEC, A1, A2, A3, L4, L5, S4, J3, SKIP, EX, HALT).
  - opcode constants.
  - read/write/inc/alu encoding constants.
  - ctrl_word struct {alu_con, read_en, inc_en, write_en}.
- One sub-module, cu_word_rom: pure function state+latched opcode -> ctrl_word, so it can be checked exhaustively in isolation.
- EX is one shared state for the single-cycle ops and uses the latched opcode.

Test Plan:
- Reset: hold rst_n=0 3 cycles mid-LDAC (state L4) -> next cycle all outputs 0, no RAM write; release -> F1 word read_en=2, write_en=2.
- LDAC with Processor datapath + RAM model: mem[0]=0x0001, mem[1]=0x0010, mem[0x10]=0x1234 -> AC=0x1234 after 8 cycles, PC=2.
- STAC then LDAC round trip: AC=0x00AA, STAC 0x20 -> mem[0x20]=0x00AA; write_en=7 asserted exactly one cycle.
- Conditional jumps:
  - CLAC then JMPZ 0x40 -> PC=0x40 (z=1).
  - INAC then JMPZ 0x40 -> PC increments past the operand (SKIP path, 4 cycles).
- HALT and illegal opcode:
  - opcode 0x77 behaves as NOP (3 cycles).
  - opcode 0xFF -> halted=1, outputs stay zero for 100 cycles.
- With CU_INSTR_COUNT_EN: 5 instructions then HALT -> instr_count=5. Preload the counter near 0xFFFF -> wraps to 0.
